// File: rtl/cubic_mac4_if.sv
// Stream bus for cubic_mac4: pixel window in with cubic_table coefficients, one
// interpolated pixel out plus a per-frame clamp counter.
interface cubic_mac4_if #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int COE_WIDTH    = 10,
    parameter int SATCNT_WIDTH = 16
);
    logic                    s_valid;
    logic                    s_sof;
    logic                    s_eol;
    logic [PIXEL_WIDTH-1:0]  s_p0;
    logic [PIXEL_WIDTH-1:0]  s_p1;
    logic [PIXEL_WIDTH-1:0]  s_p2;
    logic [PIXEL_WIDTH-1:0]  s_p3;
    logic [COE_WIDTH-1:0]    f0;
    logic [COE_WIDTH-1:0]    f1;
    logic [COE_WIDTH-1:0]    f2;
    logic [COE_WIDTH-1:0]    f3;
    logic                    m_valid;
    logic                    m_sof;
    logic                    m_eol;
    logic [PIXEL_WIDTH-1:0]  m_pixel;
    logic [SATCNT_WIDTH-1:0] sat_cnt;

    modport master (
        output s_valid, s_sof, s_eol, s_p0, s_p1, s_p2, s_p3, f0, f1, f2, f3,
        input  m_valid, m_sof, m_eol, m_pixel, sat_cnt
    );

    modport slave (
        input  s_valid, s_sof, s_eol, s_p0, s_p1, s_p2, s_p3, f0, f1, f2, f3,
        output m_valid, m_sof, m_eol, m_pixel, sat_cnt
    );
endinterface

// File: rtl/cubic_mac4.sv
// 4-tap cubic interpolation MAC: align pixels with cubic_table coefficients, sum products,
// normalise, clamp. Define CUBIC_MAC4_ROUND_EN for round-half-up instead of floor.
module cubic_mac4 #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int COE_WIDTH    = 10,
    parameter int SATCNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cubic_mac4_if.slave  bus
);
    localparam int PROD_W = PIXEL_WIDTH + COE_WIDTH + 1;
    localparam int PAIR_W = PROD_W + 1;
    localparam int SUM_W  = PROD_W + 2;
    localparam int SHIFT  = COE_WIDTH - 2;

    logic [3:0][PIXEL_WIDTH-1:0] s_p;
    logic [3:0][COE_WIDTH-1:0]   f_in;

    assign s_p  = {bus.s_p3, bus.s_p2, bus.s_p1, bus.s_p0};
    assign f_in = {bus.f3, bus.f2, bus.f1, bus.f0};

    // Stage A: pixels wait one cycle for the table's registered coefficients
    logic                        a_valid_reg, a_sof_reg, a_eol_reg;
    logic [3:0][PIXEL_WIDTH-1:0] a_p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_reg <= 1'b0;
            a_sof_reg   <= 1'b0;
            a_eol_reg   <= 1'b0;
            a_p_reg     <= '0;
        end else begin
            a_valid_reg <= bus.s_valid;
            a_sof_reg   <= bus.s_valid & bus.s_sof;
            a_eol_reg   <= bus.s_valid & bus.s_eol;
            a_p_reg     <= s_p;
        end
    end

    // Stage B: unsigned pixel times signed coefficient, full precision
    logic [3:0][PROD_W-1:0] prod_next;
    logic [3:0][PROD_W-1:0] b_prod_reg;
    logic                   b_valid_reg, b_sof_reg, b_eol_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_tap
        logic signed [PROD_W-1:0] p_ext;
        logic signed [PROD_W-1:0] f_ext;
        assign p_ext         = $signed({{(COE_WIDTH + 1){1'b0}}, a_p_reg[gi]});
        assign f_ext         = $signed({{(PIXEL_WIDTH + 1){f_in[gi][COE_WIDTH-1]}}, f_in[gi]});
        assign prod_next[gi] = p_ext * f_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_reg <= 1'b0;
            b_sof_reg   <= 1'b0;
            b_eol_reg   <= 1'b0;
            b_prod_reg  <= '0;
        end else begin
            b_valid_reg <= a_valid_reg;
            b_sof_reg   <= a_valid_reg & a_sof_reg;
            b_eol_reg   <= a_valid_reg & a_eol_reg;
            b_prod_reg  <= prod_next;
        end
    end

    // Stages C and D: two-level adder tree, sign-extended one bit per level
    logic signed [PAIR_W-1:0] c_pair0_reg, c_pair1_reg;
    logic                     c_valid_reg, c_sof_reg, c_eol_reg;
    logic signed [SUM_W-1:0]  d_sum_reg;
    logic                     d_valid_reg, d_sof_reg, d_eol_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid_reg <= 1'b0;
            c_sof_reg   <= 1'b0;
            c_eol_reg   <= 1'b0;
            c_pair0_reg <= '0;
            c_pair1_reg <= '0;
            d_valid_reg <= 1'b0;
            d_sof_reg   <= 1'b0;
            d_eol_reg   <= 1'b0;
            d_sum_reg   <= '0;
        end else begin
            c_valid_reg <= b_valid_reg;
            c_sof_reg   <= b_valid_reg & b_sof_reg;
            c_eol_reg   <= b_valid_reg & b_eol_reg;
            c_pair0_reg <= $signed({b_prod_reg[0][PROD_W-1], b_prod_reg[0]})
                         + $signed({b_prod_reg[1][PROD_W-1], b_prod_reg[1]});
            c_pair1_reg <= $signed({b_prod_reg[2][PROD_W-1], b_prod_reg[2]})
                         + $signed({b_prod_reg[3][PROD_W-1], b_prod_reg[3]});
            d_valid_reg <= c_valid_reg;
            d_sof_reg   <= c_valid_reg & c_sof_reg;
            d_eol_reg   <= c_valid_reg & c_eol_reg;
            d_sum_reg   <= $signed({c_pair0_reg[PAIR_W-1], c_pair0_reg})
                         + $signed({c_pair1_reg[PAIR_W-1], c_pair1_reg});
        end
    end

    // Stage E: normalise by unity gain, then clamp into the pixel range
    logic signed [SUM_W-1:0] rnd_sum;
    logic signed [SUM_W-1:0] shifted;
    logic                    clamp_lo, clamp_hi, clamp;
    logic [PIXEL_WIDTH-1:0]  pix_next;
    logic [SATCNT_WIDTH-1:0] sat_next;
    logic [SATCNT_WIDTH-1:0] sat_cnt_reg;
    logic                    m_valid_reg, m_sof_reg, m_eol_reg;
    logic [PIXEL_WIDTH-1:0]  m_pixel_reg;

`ifdef CUBIC_MAC4_ROUND_EN
    localparam logic signed [SUM_W-1:0] ROUND_ADD = SUM_W'(1) << (COE_WIDTH - 3);
    assign rnd_sum = d_sum_reg + ROUND_ADD;
`else
    assign rnd_sum = d_sum_reg;
`endif

    always_comb begin
        shifted  = rnd_sum >>> SHIFT;
        clamp_lo = shifted[SUM_W-1];
        clamp_hi = !shifted[SUM_W-1] && (|shifted[SUM_W-2:PIXEL_WIDTH]);
        clamp    = clamp_lo | clamp_hi;
        pix_next = shifted[PIXEL_WIDTH-1:0];
        if (clamp_lo) begin
            pix_next = '0;
        end else if (clamp_hi) begin
            pix_next = '1;
        end
        // A frame start restarts the count, including its own clamp
        sat_next = sat_cnt_reg;
        if (d_sof_reg) begin
            sat_next = clamp ? SATCNT_WIDTH'(1) : '0;
        end else if (clamp && !(&sat_cnt_reg)) begin
            sat_next = sat_cnt_reg + SATCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            m_sof_reg   <= 1'b0;
            m_eol_reg   <= 1'b0;
            m_pixel_reg <= '0;
            sat_cnt_reg <= '0;
        end else begin
            m_valid_reg <= d_valid_reg;
            m_sof_reg   <= d_valid_reg & d_sof_reg;
            m_eol_reg   <= d_valid_reg & d_eol_reg;
            if (d_valid_reg) begin
                m_pixel_reg <= pix_next;
                sat_cnt_reg <= sat_next;
            end
        end
    end

    assign bus.m_valid = m_valid_reg;
    assign bus.m_sof   = m_sof_reg;
    assign bus.m_eol   = m_eol_reg;
    assign bus.m_pixel = m_pixel_reg;
    assign bus.sat_cnt = sat_cnt_reg;
endmodule

// File: tb/tb_cubic_mac4.sv
// Directed bench for cubic_mac4 with a registered stand-in for cubic_table's coefficient output.
module tb_cubic_mac4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cubic_mac4_if #(.PIXEL_WIDTH(8), .COE_WIDTH(10), .SATCNT_WIDTH(16)) bus ();

    cubic_mac4 #(.PIXEL_WIDTH(8), .COE_WIDTH(10), .SATCNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Coefficients chosen alongside s_valid appear on f0..f3 one edge later, like cubic_table
    logic [9:0] coef [4];
    always @(posedge clk) begin
        bus.f0 <= coef[0];
        bus.f1 <= coef[1];
        bus.f2 <= coef[2];
        bus.f3 <= coef[3];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_window(input int p0, input int p1, input int p2, input int p3,
                                input int f0, input int f1, input int f2, input int f3,
                                input bit sof, input bit eol);
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        bus.s_p0 = 8'(p0); bus.s_p1 = 8'(p1); bus.s_p2 = 8'(p2); bus.s_p3 = 8'(p3);
        coef[0] = 10'(f0); coef[1] = 10'(f1); coef[2] = 10'(f2); coef[3] = 10'(f3);
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
    endtask

    // Counts edges after the sampling edge until m_valid; bounded at 10
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.m_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic int model_pix(input int p0, input int p1, input int p2, input int p3,
                                     input int f0, input int f1, input int f2, input int f3,
                                     output bit clamped);
        int sum;
        int q;
        sum = p0 * f0 + p1 * f1 + p2 * f2 + p3 * f3;
`ifdef CUBIC_MAC4_ROUND_EN
        sum = sum + 128;
`endif
        q = (sum >= 0) ? (sum / 256) : -((-sum + 255) / 256);
        clamped = (q < 0) || (q > 255);
        if (q < 0) q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    typedef struct {
        int p0, p1, p2, p3;
        int f0, f1, f2, f3;
        bit sof, eol;
        int pix_floor, pix_round;
        int sat_floor, sat_round;
    } vec_t;

    vec_t vecs [10];

    task automatic set_vec(input int i, input int p0, input int p1, input int p2, input int p3,
                           input int f0, input int f1, input int f2, input int f3,
                           input bit sof, input bit eol,
                           input int pf, input int pr, input int sf, input int sr);
        vecs[i] = '{p0, p1, p2, p3, f0, f1, f2, f3, sof, eol, pf, pr, sf, sr};
    endtask

    int sp [16][4];
    int sfc [16][4];
    int exp_pix [16];
    int exp_sat;

    initial begin
        int lat;
        int j;
        int exp_p;
        int exp_s;
        bit cl;

        // pixels      coefficients          sof eol  pix(floor,round) sat(floor,round)
        set_vec(0, 9, 100, 7, 3,    0, 256, 0, 0,        1, 0, 100, 100, 0, 0);
        set_vec(1, 0, 255, 0, 0,    0, 288, 0, -32,      0, 0, 255, 255, 1, 1);
        set_vec(2, 255, 0, 0, 255,  -32, 160, 160, -32,  0, 1, 0, 0, 2, 2);
        set_vec(3, 255, 0, 0, 255,  -32, 160, 160, -32,  1, 0, 0, 0, 1, 1);
        set_vec(4, 0, 1, 2, 0,      0, 128, 128, 0,      0, 0, 1, 2, 1, 1);
        set_vec(5, 10, 20, 30, 40,  -16, 144, 144, -16,  0, 1, 25, 25, 1, 1);
        set_vec(6, 0, 255, 0, 0,    0, 256, 0, 0,        0, 0, 255, 255, 1, 1);
        set_vec(7, 1, 0, 0, 0,      -1, 0, 0, 0,         0, 0, 0, 0, 2, 1);
        set_vec(8, 0, 255, 1, 0,    0, 256, 128, 0,      0, 0, 255, 255, 2, 2);
        set_vec(9, 0, 42, 0, 0,     0, 256, 0, 0,        1, 0, 42, 42, 0, 0);

        // Reset with random inputs
        for (int c = 0; c < 6; c++) begin
            bus.s_valid = 1'($urandom); bus.s_sof = 1'($urandom); bus.s_eol = 1'($urandom);
            bus.s_p0 = 8'($urandom); bus.s_p1 = 8'($urandom);
            bus.s_p2 = 8'($urandom); bus.s_p3 = 8'($urandom);
            for (int k = 0; k < 4; k++) coef[k] = 10'($urandom);
            @(posedge clk); #1;
        end
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_m_sof",   32'(bus.m_sof), 0);
        check("rst_m_eol",   32'(bus.m_eol), 0);
        check("rst_m_pixel", 32'(bus.m_pixel), 0);
        check("rst_sat_cnt", 32'(bus.sat_cnt), 0);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single-window vectors: latency, value, sideband, sat count, one-cycle pulse
        for (int i = 0; i < 10; i++) begin
            drive_window(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                         vecs[i].f0, vecs[i].f1, vecs[i].f2, vecs[i].f3,
                         vecs[i].sof, vecs[i].eol);
            @(posedge clk); #1;
            idle();
            wait_out(lat);
`ifdef CUBIC_MAC4_ROUND_EN
            exp_p = vecs[i].pix_round;
            exp_s = vecs[i].sat_round;
`else
            exp_p = vecs[i].pix_floor;
            exp_s = vecs[i].sat_floor;
`endif
            $display("[TB] vec %0d lat=%0d pix=%0d sof=%0d eol=%0d sat=%0d",
                     i, lat, bus.m_pixel, bus.m_sof, bus.m_eol, bus.sat_cnt);
            check("vec_latency", 32'(lat), 4);
            check("vec_pixel",   32'(bus.m_pixel), 32'(exp_p));
            check("vec_sof",     32'(bus.m_sof), 32'(vecs[i].sof));
            check("vec_eol",     32'(bus.m_eol), 32'(vecs[i].eol));
            check("vec_sat",     32'(bus.sat_cnt), 32'(exp_s));
            @(posedge clk); #1;
            check("vec_one_cycle", 32'(bus.m_valid), 0);
            repeat (2) @(posedge clk);
            #1;
        end

        // Stream of 16 back-to-back windows, one forced clamp
        exp_sat = 0;
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 4; k++) begin
                sp[w][k]  = int'($urandom_range(255, 0));
                sfc[w][k] = int'($urandom_range(384, 0)) - 64;
            end
            if (w == 5) begin
                sp[w]  = '{0, 255, 0, 0};
                sfc[w] = '{0, 288, 0, -32};
            end
            exp_pix[w] = model_pix(sp[w][0], sp[w][1], sp[w][2], sp[w][3],
                                   sfc[w][0], sfc[w][1], sfc[w][2], sfc[w][3], cl);
            if (w == 0) exp_sat = cl ? 1 : 0;
            else if (cl) exp_sat++;
        end
        for (int t = 0; t < 23; t++) begin
            j = t - 5;
            check("stream_valid", 32'(bus.m_valid), 32'((j >= 0 && j < 16) ? 1 : 0));
            if (j >= 0 && j < 16) begin
                $display("[TB] stream %0d pix=%0d exp=%0d", j, bus.m_pixel, exp_pix[j]);
                check("stream_pixel", 32'(bus.m_pixel), 32'(exp_pix[j]));
                check("stream_sof",   32'(bus.m_sof), 32'(j == 0));
                check("stream_eol",   32'(bus.m_eol), 32'(j == 15));
            end
            if (t < 16) begin
                drive_window(sp[t][0], sp[t][1], sp[t][2], sp[t][3],
                             sfc[t][0], sfc[t][1], sfc[t][2], sfc[t][3], t == 0, t == 15);
            end else begin
                idle();
            end
            @(posedge clk); #1;
        end
        check("stream_sat", 32'(bus.sat_cnt), 32'(exp_sat));

        // Mid-stream reset with three windows in flight
        drive_window(0, 255, 0, 0, 0, 288, 0, -32, 1, 0);
        @(posedge clk); #1;
        drive_window(0, 200, 0, 0, 0, 256, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive_window(0, 255, 0, 0, 0, 288, 0, -32, 0, 1);
        @(posedge clk); #1;
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst_sat", 32'(bus.sat_cnt), 0);
        for (int c = 0; c < 6; c++) begin
            check("mrst_no_valid", 32'(bus.m_valid), 0);
            @(posedge clk); #1;
        end
        drive_window(0, 77, 0, 0, 0, 256, 0, 0, 0, 0);
        @(posedge clk); #1;
        idle();
        wait_out(lat);
        $display("[TB] post-reset lat=%0d pix=%0d sat=%0d", lat, bus.m_pixel, bus.sat_cnt);
        check("mrst_latency", 32'(lat), 4);
        check("mrst_pixel",   32'(bus.m_pixel), 77);
        check("mrst_sat_after", 32'(bus.sat_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
